// File: rtl/bd_tag_stream_arbiter.sv
// Merges the local-tag, global-tag and other-word streams from the BD tag
// splitter into one registered upstream word channel. Arbitration is
// round-robin with a per-owner burst limit. Each source has an enable bit
// and a saturating accept counter.
module bd_tag_stream_arbiter #(
   parameter int NBDdata_in = 34,
   parameter int NBDcode    = 4,
   parameter int Nglobal    = 12,
   parameter int Ntag       = 11,
   parameter int Nct        = 9,
   parameter int Ncnt       = 16,
   parameter int Nburst     = 4
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        tag_v,
   input  logic [Ntag+Nct-1:0]         tag_data,
   output logic                        tag_a,
   input  logic                        gtag_v,
   input  logic [Nglobal+Ntag+Nct-1:0] gtag_data,
   output logic                        gtag_a,
   input  logic                        oth_v,
   input  logic [NBDdata_in-1:0]       oth_payload,
   input  logic [NBDcode-1:0]          oth_code,
   output logic                        oth_a,
   input  logic [2:0]                  conf_en,
   input  logic [Nburst-1:0]           conf_burst,
   output logic                        out_v,
   output logic [1:0]                  out_src,
   output logic [NBDcode-1:0]          out_code,
   output logic [NBDdata_in-1:0]       out_payload,
   input  logic                        out_a,
   output logic [Ncnt-1:0]             cnt_gtag,
   output logic [Ncnt-1:0]             cnt_tag,
   output logic [Ncnt-1:0]             cnt_oth
);

   localparam int NTAGW  = Ntag + Nct;
   localparam int NGTAGW = Nglobal + Ntag + Nct;

   localparam logic [1:0] SRC_GTAG = 2'd0;
   localparam logic [1:0] SRC_TAG  = 2'd1;
   localparam logic [1:0] SRC_OTH  = 2'd2;

   logic [3:0]            elig;
   logic [1:0]            ptr, owner, winner, cand;
   logic [1:0]            ptr_nxt, owner_nxt;
   logic [Nburst-1:0]     burst_cnt, burst_nxt, burst_inc, limit;
   logic                  win_found, owner_hold, load, grant;
   logic [NBDdata_in-1:0] pay_sel;
   logic [NBDcode-1:0]    code_sel;

   function automatic logic [1:0] inc3(input logic [1:0] x);
      return (x == 2'd2) ? 2'd0 : x + 2'd1;
   endfunction

   // Bit 3 is a permanently ineligible pad so a 2-bit index stays in range.
   assign elig       = {1'b0, oth_v & conf_en[2], tag_v & conf_en[1], gtag_v & conf_en[0]};
   assign limit      = (conf_burst == '0) ? Nburst'(1) : conf_burst;
   // burst_cnt == 0 means the burst has ended (limit reached or idle cycle).
   assign owner_hold = elig[owner] && (burst_cnt != '0) && (burst_cnt < limit);
   assign load       = ~out_v | out_a;
   // Gating with reset keeps all input acks low while reset is held.
   assign grant      = load & win_found & reset;

   assign gtag_a = grant & (winner == SRC_GTAG);
   assign tag_a  = grant & (winner == SRC_TAG);
   assign oth_a  = grant & (winner == SRC_OTH);

   // Winner select: burst owner first, otherwise circular scan from ptr.
   always_comb begin
      win_found = 1'b0;
      winner    = owner;
      cand      = ptr;
      if (owner_hold) begin
         win_found = 1'b1;
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (!win_found && elig[cand]) begin
               win_found = 1'b1;
               winner    = cand;
            end
            cand = inc3(cand);
         end
      end
   end

   // Next owner / pointer / burst count.
   always_comb begin
      ptr_nxt   = ptr;
      owner_nxt = owner;
      burst_nxt = burst_cnt;
      burst_inc = (winner == owner) ? burst_cnt + Nburst'(1) : Nburst'(1);
      if (grant) begin
         owner_nxt = winner;
         if (burst_inc >= limit) begin
            ptr_nxt   = inc3(winner);
            burst_nxt = '0;
         end else begin
            burst_nxt = burst_inc;
         end
      end else if (load) begin
         burst_nxt = '0;
      end
   end

   // Output word mux; tag sources are zero-extended with a zero leaf code.
   always_comb begin
      pay_sel  = '0;
      code_sel = '0;
      case (winner)
         SRC_GTAG: pay_sel = {{(NBDdata_in-NGTAGW){1'b0}}, gtag_data};
         SRC_TAG:  pay_sel = {{(NBDdata_in-NTAGW){1'b0}}, tag_data};
         SRC_OTH: begin
            pay_sel  = oth_payload;
            code_sel = oth_code;
         end
         default: pay_sel = '0;
      endcase
   end

   // Arbiter state and output register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ptr         <= '0;
         owner       <= '0;
         burst_cnt   <= '0;
         out_v       <= 1'b0;
         out_src     <= '0;
         out_code    <= '0;
         out_payload <= '0;
      end else begin
         ptr       <= ptr_nxt;
         owner     <= owner_nxt;
         burst_cnt <= burst_nxt;
         if (grant) begin
            out_v       <= 1'b1;
            out_src     <= winner;
            out_code    <= code_sel;
            out_payload <= pay_sel;
         end else if (load) begin
            out_v <= 1'b0;
         end
      end
   end

   // Saturating per-source accept counters.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_gtag <= '0;
         cnt_tag  <= '0;
         cnt_oth  <= '0;
      end else begin
         if (gtag_a && (cnt_gtag != '1)) cnt_gtag <= cnt_gtag + Ncnt'(1);
         if (tag_a  && (cnt_tag  != '1)) cnt_tag  <= cnt_tag  + Ncnt'(1);
         if (oth_a  && (cnt_oth  != '1)) cnt_oth  <= cnt_oth  + Ncnt'(1);
      end
   end

endmodule

// File: tb/tb_bd_tag_stream_arbiter.sv
// Directed bench for bd_tag_stream_arbiter: a table of per-cycle vectors
// plus hand-written sequences for saturation and asynchronous reset.
module tb_bd_tag_stream_arbiter;

   localparam int NBD = 34, NCODE = 4, NG = 12, NT = 11, NC = 9, NCNT = 16, NB = 4;

   localparam logic [NG+NT+NC-1:0] GDATA = 32'hA5C3_1F07;
   localparam logic [NT+NC-1:0]    TDATA = 20'h050A3;
   localparam logic [NBD-1:0]      OPAY  = 34'h2_DEAD_BEEF;
   localparam logic [NCODE-1:0]    OCODE = 4'hB;

   logic clk, reset;
   logic tag_v, gtag_v, oth_v, out_a;
   logic [NT+NC-1:0] tag_data;
   logic [NG+NT+NC-1:0] gtag_data;
   logic [NBD-1:0] oth_payload;
   logic [NCODE-1:0] oth_code;
   logic [2:0] conf_en;
   logic [NB-1:0] conf_burst;
   logic tag_a, gtag_a, oth_a, out_v;
   logic [1:0] out_src;
   logic [NCODE-1:0] out_code;
   logic [NBD-1:0] out_payload;
   logic [NCNT-1:0] cnt_gtag, cnt_tag, cnt_oth;
   // Narrow-counter copy driven by the same stimulus
   logic tag_a4, gtag_a4, oth_a4, out_v4;
   logic [1:0] out_src4;
   logic [NCODE-1:0] out_code4;
   logic [NBD-1:0] out_payload4;
   logic [3:0] cnt_gtag4, cnt_tag4, cnt_oth4;

   bd_tag_stream_arbiter dut (
      .clk(clk), .reset(reset),
      .tag_v(tag_v), .tag_data(tag_data), .tag_a(tag_a),
      .gtag_v(gtag_v), .gtag_data(gtag_data), .gtag_a(gtag_a),
      .oth_v(oth_v), .oth_payload(oth_payload), .oth_code(oth_code), .oth_a(oth_a),
      .conf_en(conf_en), .conf_burst(conf_burst),
      .out_v(out_v), .out_src(out_src), .out_code(out_code), .out_payload(out_payload),
      .out_a(out_a), .cnt_gtag(cnt_gtag), .cnt_tag(cnt_tag), .cnt_oth(cnt_oth)
   );

   bd_tag_stream_arbiter #(.Ncnt(4)) dut4 (
      .clk(clk), .reset(reset),
      .tag_v(tag_v), .tag_data(tag_data), .tag_a(tag_a4),
      .gtag_v(gtag_v), .gtag_data(gtag_data), .gtag_a(gtag_a4),
      .oth_v(oth_v), .oth_payload(oth_payload), .oth_code(oth_code), .oth_a(oth_a4),
      .conf_en(conf_en), .conf_burst(conf_burst),
      .out_v(out_v4), .out_src(out_src4), .out_code(out_code4), .out_payload(out_payload4),
      .out_a(out_a), .cnt_gtag(cnt_gtag4), .cnt_tag(cnt_tag4), .cnt_oth(cnt_oth4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [2:0] v;      // {oth, tag, gtag}
      logic [2:0] en;
      logic [3:0] burst;
      logic       oa;
      logic [2:0] acks;   // expected {oth_a, tag_a, gtag_a}
      logic       ov;
      logic [1:0] src;
   } vec_t;

   vec_t vecs[$];
   int n_chk = 0;
   int n_pass = 0;

   function automatic vec_t mk(input logic [2:0] v, input logic [2:0] en, input logic [3:0] burst,
                               input logic oa, input logic [2:0] acks, input logic ov,
                               input logic [1:0] src);
      vec_t t;
      t.v = v; t.en = en; t.burst = burst; t.oa = oa; t.acks = acks; t.ov = ov; t.src = src;
      return t;
   endfunction

   function automatic logic [NBD-1:0] exp_pay(input logic [1:0] src);
      case (src)
         2'd0:    return {{(NBD-NG-NT-NC){1'b0}}, GDATA};
         2'd1:    return {{(NBD-NT-NC){1'b0}}, TDATA};
         default: return OPAY;
      endcase
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   // Called at a negedge; returns at the following negedge.
   task automatic run_vec(input vec_t t, input int idx);
      {oth_v, tag_v, gtag_v} = t.v;
      conf_en = t.en;
      conf_burst = t.burst;
      out_a = t.oa;
      #1;
      chk($sformatf("acks[%0d]", idx), {61'd0, oth_a, tag_a, gtag_a}, {61'd0, t.acks});
      @(posedge clk);
      #1;
      chk($sformatf("out_v[%0d]", idx), {63'd0, out_v}, {63'd0, t.ov});
      if (t.ov) begin
         chk($sformatf("out_src[%0d]", idx), {62'd0, out_src}, {62'd0, t.src});
         chk($sformatf("out_payload[%0d]", idx), {30'd0, out_payload}, {30'd0, exp_pay(t.src)});
         chk($sformatf("out_code[%0d]", idx), {60'd0, out_code},
             (t.src == 2'd2) ? {60'd0, OCODE} : 64'd0);
      end
      @(negedge clk);
   endtask

   task automatic chk_cnt(input string tagname, input int g, input int t, input int o);
      chk({tagname, "_cnt_gtag"}, {48'd0, cnt_gtag}, 64'(g));
      chk({tagname, "_cnt_tag"},  {48'd0, cnt_tag},  64'(t));
      chk({tagname, "_cnt_oth"},  {48'd0, cnt_oth},  64'(o));
   endtask

   initial begin
      reset = 1'b0;
      {oth_v, tag_v, gtag_v} = 3'b111;
      conf_en = 3'b111; conf_burst = 4'd2; out_a = 1'b1;
      tag_data = TDATA; gtag_data = GDATA; oth_payload = OPAY; oth_code = OCODE;

      // Reset state with all sources requesting
      repeat (2) @(negedge clk);
      #1;
      chk("rst_acks", {61'd0, oth_a, tag_a, gtag_a}, 64'd0);
      chk("rst_out_v", {63'd0, out_v}, 64'd0);
      chk("rst_out_payload", {30'd0, out_payload}, 64'd0);
      chk_cnt("rst", 0, 0, 0);
      @(negedge clk);
      {oth_v, tag_v, gtag_v} = 3'b000;
      reset = 1'b1;

      // Burst of 2 rotation, all enabled
      for (int r = 0; r < 2; r++) begin
         vecs.push_back(mk(3'b111, 3'b111, 4'd2, 1'b1, 3'b001, 1'b1, 2'd0));
         vecs.push_back(mk(3'b111, 3'b111, 4'd2, 1'b1, 3'b001, 1'b1, 2'd0));
         vecs.push_back(mk(3'b111, 3'b111, 4'd2, 1'b1, 3'b010, 1'b1, 2'd1));
         vecs.push_back(mk(3'b111, 3'b111, 4'd2, 1'b1, 3'b010, 1'b1, 2'd1));
         vecs.push_back(mk(3'b111, 3'b111, 4'd2, 1'b1, 3'b100, 1'b1, 2'd2));
         vecs.push_back(mk(3'b111, 3'b111, 4'd2, 1'b1, 3'b100, 1'b1, 2'd2));
      end
      // tag disabled: gtag and other alternate
      for (int r = 0; r < 2; r++) begin
         vecs.push_back(mk(3'b111, 3'b101, 4'd2, 1'b1, 3'b001, 1'b1, 2'd0));
         vecs.push_back(mk(3'b111, 3'b101, 4'd2, 1'b1, 3'b001, 1'b1, 2'd0));
         vecs.push_back(mk(3'b111, 3'b101, 4'd2, 1'b1, 3'b100, 1'b1, 2'd2));
         vecs.push_back(mk(3'b111, 3'b101, 4'd2, 1'b1, 3'b100, 1'b1, 2'd2));
      end
      // Single source: tag granted every cycle with burst limit 1
      for (int r = 0; r < 3; r++)
         vecs.push_back(mk(3'b010, 3'b111, 4'd1, 1'b1, 3'b010, 1'b1, 2'd1));
      // Idle drains output
      vecs.push_back(mk(3'b000, 3'b111, 4'd1, 1'b1, 3'b000, 1'b0, 2'd0));
      // Backpressure on an other word
      vecs.push_back(mk(3'b100, 3'b111, 4'd1, 1'b0, 3'b100, 1'b1, 2'd2));
      for (int r = 0; r < 5; r++)
         vecs.push_back(mk(3'b100, 3'b111, 4'd1, 1'b0, 3'b000, 1'b1, 2'd2));
      vecs.push_back(mk(3'b000, 3'b111, 4'd1, 1'b1, 3'b000, 1'b0, 2'd0));
      // conf_burst = 0 behaves as 1
      vecs.push_back(mk(3'b111, 3'b111, 4'd0, 1'b1, 3'b001, 1'b1, 2'd0));
      vecs.push_back(mk(3'b111, 3'b111, 4'd0, 1'b1, 3'b010, 1'b1, 2'd1));
      vecs.push_back(mk(3'b111, 3'b111, 4'd0, 1'b1, 3'b100, 1'b1, 2'd2));
      vecs.push_back(mk(3'b111, 3'b111, 4'd0, 1'b1, 3'b001, 1'b1, 2'd0));

      foreach (vecs[i]) begin
         run_vec(vecs[i], i);
         if (i == 11) chk_cnt("rr12", 4, 4, 4);
         if (i == 19) chk_cnt("en101", 8, 4, 8);
      end
      chk_cnt("table_end", 10, 8, 10);

      // Saturation: 20 further gtag grants
      for (int r = 0; r < 20; r++)
         run_vec(mk(3'b001, 3'b111, 4'd3, 1'b1, 3'b001, 1'b1, 2'd0), 100 + r);
      chk("sat_cnt_gtag16", {48'd0, cnt_gtag}, 64'd30);
      chk("sat_cnt_gtag4", {60'd0, cnt_gtag4}, 64'd15);
      chk("sat_cnt_tag4", {60'd0, cnt_tag4}, 64'd8);
      chk("sat_cnt_oth4", {60'd0, cnt_oth4}, 64'd10);

      // Reset asserted mid-burst with a word in the output register
      run_vec(mk(3'b111, 3'b111, 4'd2, 1'b1, 3'b010, 1'b1, 2'd1), 200);
      #2;
      reset = 1'b0;
      #1;
      chk("arst_out_v", {63'd0, out_v}, 64'd0);
      chk("arst_out_src", {62'd0, out_src}, 64'd0);
      chk("arst_out_payload", {30'd0, out_payload}, 64'd0);
      chk("arst_acks", {61'd0, oth_a, tag_a, gtag_a}, 64'd0);
      chk_cnt("arst", 0, 0, 0);
      @(negedge clk);
      reset = 1'b1;
      run_vec(mk(3'b111, 3'b111, 4'd2, 1'b1, 3'b001, 1'b1, 2'd0), 201);
      chk_cnt("post_rst", 1, 0, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
